// File: rtl/ascon_pkg.sv
// ---------------------------------------------------------------------------
// ascon_pkg
// Shared definitions for the ASCON block sequencer:
//   - ascon_seq_state_t : sequencer FSM state encoding
//   - ASCON128_RATE_BYTES / ASCON128A_RATE_BYTES : rate in bytes per variant
// ---------------------------------------------------------------------------
package ascon_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        PRESENT = 2'd2,
        DONE    = 2'd3
    } ascon_seq_state_t;

    localparam int ASCON128_RATE_BYTES  = 8;
    localparam int ASCON128A_RATE_BYTES = 16;

endpackage

// File: rtl/ascon_block_sequencer_if.sv
// ---------------------------------------------------------------------------
// ascon_block_sequencer_if
// Handshake bundle between the control FSM / data source (master) and the
// block sequencer (slave).
//   master drives : start, is_ad, msg_len, abort, block_read
//   slave drives  : block_request, block_valid, datalen, last_block,
//                   blk_idx, done, len_err, idle
// ---------------------------------------------------------------------------
interface ascon_block_sequencer_if
    import ascon_pkg::*;
#(
    parameter int RATE_BYTES = ASCON128_RATE_BYTES,
    parameter int MAX_BLOCKS = 4,
    parameter int LEN_W      = $clog2(RATE_BYTES*MAX_BLOCKS+1),
    parameter int DL_W       = $clog2(RATE_BYTES+1),
    parameter int BI_W       = $clog2(MAX_BLOCKS+2)
);
    logic             start;
    logic             is_ad;
    logic [LEN_W-1:0] msg_len;
    logic             abort;
    logic             block_read;

    logic             block_request;
    logic             block_valid;
    logic [DL_W-1:0]  datalen;
    logic             last_block;
    logic [BI_W-1:0]  blk_idx;
    logic             done;
    logic             len_err;
    logic             idle;

    modport master (
        output start, is_ad, msg_len, abort, block_read,
        input  block_request, block_valid, datalen, last_block,
               blk_idx, done, len_err, idle
    );

    modport slave (
        input  start, is_ad, msg_len, abort, block_read,
        output block_request, block_valid, datalen, last_block,
               blk_idx, done, len_err, idle
    );
endinterface

// File: rtl/ascon_block_sequencer.sv
// ---------------------------------------------------------------------------
// ascon_block_sequencer
// Splits a byte-length message into rate-sized blocks, presenting one block
// at a time with its byte count, index and last-block flag. Appends the
// padding block (datalen=0) when the length is an exact multiple of the rate,
// and skips empty associated data.
// Ports:
//   clk  : clock, rising edge
//   RST  : synchronous active-high reset
//   bus  : ascon_block_sequencer_if.slave (control inputs, block outputs)
// Every output is a flop; nothing combinational reaches the bus outputs.
// ---------------------------------------------------------------------------
module ascon_block_sequencer
    import ascon_pkg::*;
#(
    parameter int RATE_BYTES = ASCON128_RATE_BYTES,
    parameter int MAX_BLOCKS = 4,
    parameter int LEN_W      = $clog2(RATE_BYTES*MAX_BLOCKS+1),
    parameter int DL_W       = $clog2(RATE_BYTES+1),
    parameter int BI_W       = $clog2(MAX_BLOCKS+2)
) (
    input  logic                    clk,
    input  logic                    RST,
    ascon_block_sequencer_if.slave  bus
);

    localparam logic [LEN_W-1:0] RATE_L  = LEN_W'(RATE_BYTES);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(RATE_BYTES*MAX_BLOCKS);

    ascon_seq_state_t  state_q;
    logic [LEN_W-1:0]  rem_q;
    logic [BI_W-1:0]   idx_q;
    logic              req_q;
    logic              valid_q;
    logic [DL_W-1:0]   dl_q;
    logic              last_q;
    logic              done_q;
    logic              err_q;
    logic              idle_q;

    // Byte count of the block about to be presented, clamped to the rate.
    function automatic logic [DL_W-1:0] sat_datalen(input logic [LEN_W-1:0] rem);
        return (rem < RATE_L) ? DL_W'(rem) : DL_W'(RATE_BYTES);
    endfunction

    always_ff @(posedge clk) begin
        if (RST || bus.abort) begin
            state_q <= IDLE;
            rem_q   <= '0;
            idx_q   <= '0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            dl_q    <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            idle_q  <= 1'b1;
        end else begin
            // Strobe outputs default low so each is a single-cycle pulse.
            req_q  <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    idle_q <= 1'b1;
                    if (bus.start) begin
                        if (bus.msg_len > MAX_LEN) begin
                            err_q <= 1'b1;
                        end else if (bus.is_ad && (bus.msg_len == '0)) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            idle_q  <= 1'b0;
                        end else begin
                            rem_q   <= bus.msg_len;
                            idx_q   <= '0;
                            state_q <= REQ;
                            req_q   <= 1'b1;
                            idle_q  <= 1'b0;
                        end
                    end
                end
                REQ: begin
                    state_q <= PRESENT;
                    valid_q <= 1'b1;
                    dl_q    <= sat_datalen(rem_q);
                    // remaining==0 lands here too: that is the padding block.
                    last_q  <= (rem_q < RATE_L);
                end
                PRESENT: begin
                    if (bus.block_read) begin
                        valid_q <= 1'b0;
                        dl_q    <= '0;
                        last_q  <= 1'b0;
                        if (last_q) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            // last_q==0 guarantees rem_q >= RATE, so no underflow.
                            rem_q   <= rem_q - RATE_L;
                            idx_q   <= idx_q + BI_W'(1);
                            state_q <= REQ;
                            req_q   <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    idle_q  <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    idle_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.block_request = req_q;
    assign bus.block_valid   = valid_q;
    assign bus.datalen       = dl_q;
    assign bus.last_block    = last_q;
    assign bus.blk_idx       = idx_q;
    assign bus.done          = done_q;
    assign bus.len_err       = err_q;
    assign bus.idle          = idle_q;

endmodule

// File: tb/tb_ascon_block_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ascon_block_sequencer
// Table-driven bench for ascon_block_sequencer (RATE_BYTES=8, MAX_BLOCKS=4)
// with a scoreboard of expected blocks, plus hand-written abort and
// mid-message reset sequences.
// ---------------------------------------------------------------------------
module tb_ascon_block_sequencer;
    import ascon_pkg::*;

    localparam int RATE   = 8;
    localparam int MAXB   = 4;
    localparam int LEN_W  = $clog2(RATE*MAXB+1);
    localparam int MAXLEN = RATE*MAXB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ascon_block_sequencer_if #(.RATE_BYTES(RATE), .MAX_BLOCKS(MAXB)) bus ();

    ascon_block_sequencer #(.RATE_BYTES(RATE), .MAX_BLOCKS(MAXB)) dut (
        .clk (clk),
        .RST (rst),
        .bus (bus)
    );

    typedef struct {
        logic ad;
        int   len;
        int   stall;      // cycles to hold block_read low on the first block
        int   poke;       // pulse start during PRESENT and during DONE
        int   exp_blocks;
        logic exp_err;
    } vec_t;

    typedef struct {
        int   dl;
        logic last;
        int   idx;
    } blk_t;

    blk_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".idle"},    32'(bus.idle), 1);
        check({tag, ".req"},     32'(bus.block_request), 0);
        check({tag, ".valid"},   32'(bus.block_valid), 0);
        check({tag, ".datalen"}, 32'(bus.datalen), 0);
        check({tag, ".last"},    32'(bus.last_block), 0);
        check({tag, ".blk_idx"}, 32'(bus.blk_idx), 0);
        check({tag, ".done"},    32'(bus.done), 0);
        check({tag, ".len_err"}, 32'(bus.len_err), 0);
    endtask

    // Reference model: blocks the spec demands for a message.
    task automatic push_expected(input logic ad, input int len);
        int rem;
        int idx;
        blk_t b;
        if (len > MAXLEN || (ad && len == 0)) return;
        rem = len;
        idx = 0;
        forever begin
            b.dl   = (rem < RATE) ? rem : RATE;
            b.last = (rem < RATE);
            b.idx  = idx;
            sb.push_back(b);
            if (rem < RATE) break;
            rem -= RATE;
            idx++;
        end
    endtask

    task automatic run_msg(input vec_t v, input string tag);
        int   reqs = 0;
        int   blocks = 0;
        int   stalled = 0;
        int   done_seen = 0;
        int   err_seen = 0;
        logic skip;
        logic last_read_prev = 1'b0;
        logic poked_present = 1'b0;
        logic [31:0] h_dl, h_last, h_idx;
        blk_t e;
        h_dl = 0; h_last = 0; h_idx = 0;
        skip = v.ad && (v.len == 0);
        push_expected(v.ad, v.len);

        @(negedge clk);
        bus.is_ad   = v.ad;
        bus.msg_len = LEN_W'(v.len);
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;

        for (int cyc = 0; cyc < 80; cyc++) begin
            bus.start = 1'b0;
            if (cyc == 0) begin
                if (v.exp_err)   check({tag, ".len_err_first"}, 32'(bus.len_err), 1);
                else if (skip)   check({tag, ".skip_done_first"}, 32'(bus.done), 1);
                else             check({tag, ".req_first"}, 32'(bus.block_request), 1);
            end
            if (v.exp_err) check({tag, ".err_idle"}, 32'(bus.idle), 1);
            if (bus.block_request) reqs++;
            if (bus.len_err) err_seen++;

            if (bus.done) begin
                done_seen++;
                if (!skip) check({tag, ".done_after_last_read"}, 32'(last_read_prev), 1);
                if (v.poke != 0) bus.start = 1'b1;
                bus.block_read = 1'b0;
                @(negedge clk);
                bus.start = 1'b0;
                check({tag, ".idle_after_done"}, 32'(bus.idle), 1);
                check({tag, ".no_req_after_done"}, 32'(bus.block_request), 0);
                @(negedge clk);
                check({tag, ".no_req_after_done2"}, 32'(bus.block_request), 0);
                break;
            end

            last_read_prev = 1'b0;
            if (bus.block_valid) begin
                if (blocks == 0 && stalled < v.stall) begin
                    if (stalled == 0) begin
                        h_dl = 32'(bus.datalen); h_last = 32'(bus.last_block); h_idx = 32'(bus.blk_idx);
                    end else begin
                        check({tag, ".stall_datalen"}, 32'(bus.datalen), h_dl);
                        check({tag, ".stall_last"},    32'(bus.last_block), h_last);
                        check({tag, ".stall_idx"},     32'(bus.blk_idx), h_idx);
                    end
                    stalled++;
                    bus.block_read = 1'b0;
                end else begin
                    if (sb.size() == 0) begin
                        check({tag, ".unexpected_block"}, 32'(bus.blk_idx), 32'hFFFF_FFFF);
                    end else begin
                        e = sb.pop_front();
                        check({tag, ".datalen"}, 32'(bus.datalen), 32'(e.dl));
                        check({tag, ".last"},    32'(bus.last_block), 32'(e.last));
                        check({tag, ".blk_idx"}, 32'(bus.blk_idx), 32'(e.idx));
                    end
                    blocks++;
                    bus.block_read = 1'b1;
                    last_read_prev = bus.last_block;
                end
                if (v.poke != 0 && !poked_present) begin
                    bus.start   = 1'b1;
                    bus.msg_len = LEN_W'(3);
                    poked_present = 1'b1;
                end
            end else begin
                bus.block_read = 1'b0;
            end

            if (v.exp_err && cyc == 4) break;
            @(negedge clk);
        end
        bus.start = 1'b0;
        bus.block_read = 1'b0;

        check({tag, ".requests"}, 32'(reqs), 32'(v.exp_blocks));
        check({tag, ".blocks"},   32'(blocks), 32'(v.exp_blocks));
        check({tag, ".sb_empty"}, 32'(sb.size()), 0);
        check({tag, ".done_cnt"}, 32'(done_seen), v.exp_err ? 0 : 1);
        check({tag, ".err_cnt"},  32'(err_seen), v.exp_err ? 1 : 0);
        sb.delete();
    endtask

    vec_t vecs[9];
    vec_t v_fresh;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 13, 0, 0, 2, 1'b0};
        vecs[1] = '{1'b0, 16, 0, 0, 3, 1'b0};
        vecs[2] = '{1'b1,  0, 0, 0, 0, 1'b0};
        vecs[3] = '{1'b0,  0, 0, 0, 1, 1'b0};
        vecs[4] = '{1'b1, 33, 0, 0, 0, 1'b1};
        vecs[5] = '{1'b0, 32, 0, 0, 5, 1'b0};
        vecs[6] = '{1'b0, 20, 5, 1, 3, 1'b0};
        vecs[7] = '{1'b1,  8, 0, 1, 2, 1'b0};
        vecs[8] = '{1'b0,  7, 0, 0, 1, 1'b0};

        bus.start = 1'b0; bus.is_ad = 1'b0; bus.msg_len = '0;
        bus.abort = 1'b0; bus.block_read = 1'b0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_msg(vecs[i], $sformatf("vec%0d", i));
        end

        // Abort on block 1 of a 3-block message, together with block_read.
        begin
            int found = 0;
            @(negedge clk);
            bus.is_ad = 1'b0; bus.msg_len = LEN_W'(16); bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
            for (int c = 0; c < 20; c++) begin
                if (bus.block_valid && bus.blk_idx == 1) begin found = 1; break; end
                bus.block_read = bus.block_valid;
                @(negedge clk);
            end
            check("abort.found_blk1", 32'(found), 1);
            bus.abort = 1'b1; bus.block_read = 1'b1;
            @(negedge clk);
            bus.abort = 1'b0; bus.block_read = 1'b0;
            check_reset_outputs("abort");
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                check("abort.no_done", 32'(bus.done), 0);
                check("abort.no_req",  32'(bus.block_request), 0);
            end
            v_fresh = '{1'b1, 13, 0, 0, 2, 1'b0};
            run_msg(v_fresh, "fresh");
        end

        // Synchronous reset while in REQ, with abort also high.
        begin
            @(negedge clk);
            bus.is_ad = 1'b0; bus.msg_len = LEN_W'(24); bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
            check("rstreq.in_req", 32'(bus.block_request), 1);
            rst = 1'b1; bus.abort = 1'b1;
            @(negedge clk);
            rst = 1'b0; bus.abort = 1'b0;
            check_reset_outputs("rstreq");
            @(negedge clk);
            check("rstreq.stay_idle", 32'(bus.idle), 1);
            check("rstreq.no_valid",  32'(bus.block_valid), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
